// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// FIFO push/pop handshake and status bundle.
// With RAM_FIFO_ERR_FLAGS_EN defined, sticky overflow/underflow flags are added.
interface ram_fifo_ctrl_if
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
`ifdef RAM_FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

`ifdef RAM_FIFO_ERR_FLAGS_EN
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
`else
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count
  );
`endif

endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: port A writes, port B reads (and can write) with a
// registered read output. Contents are never reset.
module dual_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array writes and registered port-B read; a read sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    if (en_b) dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// RAM-backed synchronous FIFO controller.
// Optional feature macro: RAM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
// Read path: RAM registers the word at the accepting edge, the controller
// captures it one edge later into the held rd_data register.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic            clk,
  input logic            rst,
  ram_fifo_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              rd_pend;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] ram_q;
  logic              full_w;
  logic              empty_w;
  logic              wr_acc;
  logic              rd_acc;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en & ~full_w & ~rst;
  assign rd_acc  = bus.rd_en & ~empty_w & ~rst;

  dual_port_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_a   (wr_acc),
    .addr_a (wr_ptr),
    .din_a  (bus.wr_data),
    .en_b   (rd_acc),
    .we_b   (1'b0),
    .addr_b (rd_ptr),
    .din_b  ('0),
    .dout_b (ram_q)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Second read stage: capture the RAM word and flag it; rd_data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend    <= rd_acc;
      rd_valid_q <= rd_pend;
      if (rd_pend) rd_data_q <= ram_q;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;

`ifdef RAM_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky capture of refused requests, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w)  ovf_q <= 1'b1;
      if (bus.rd_en && empty_w) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl against a queue-based FIFO model.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_fifo_ctrl_if bus ();

  ram_fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0] q[$];
  bit         m_pend;
  logic [7:0] m_pend_word;
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ovf;
  bit         m_unf;

  int nw;
  int nr;
  bit w_s;
  bit r_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count",    32'(bus.count),    32'(q.size()));
    chk("full",     32'(bus.full),     32'(q.size() == DEPTH));
    chk("empty",    32'(bus.empty),    32'(q.size() == 0));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    chk("rd_data",  32'(bus.rd_data),  32'(m_data));
`ifdef RAM_FIFO_ERR_FLAGS_EN
    chk("overflow",  32'(bus.overflow),  32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
  endtask

  // One clock: drive inputs, advance the model over the edge, then compare.
  task automatic cycle(input bit r, input bit w, input logic [7:0] d, input bit rd);
    bit acc_w;
    bit acc_r;
    rst         = r;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = rd;
    if (r) begin
      q.delete();
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      acc_w = w && (q.size() < DEPTH);
      acc_r = rd && (q.size() > 0);
      if (w && !acc_w) m_ovf = 1'b1;
      if (rd && !acc_r) m_unf = 1'b1;
      m_valid = m_pend;
      if (m_pend) m_data = m_pend_word;
      m_pend = acc_r;
      if (acc_r) m_pend_word = q.pop_front();
      if (acc_w) q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;

    // reset state
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_rdata", 32'(bus.rd_data), 32'h0);

    // read on empty is refused
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    chk("empty_rd_valid", 32'(bus.rd_valid), 32'd0);
`ifdef RAM_FIFO_ERR_FLAGS_EN
    chk("unf_set", 32'(bus.underflow), 32'd1);
`endif
    cycle(1, 0, 8'h00, 0);

    // AA, BB then two reads
    cycle(0, 1, 8'hAA, 0);
    cycle(0, 1, 8'hBB, 0);
    chk("s1_count2", 32'(bus.count), 32'd2);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);
    chk("s1_first", 32'(bus.rd_data), 32'hAA);
    chk("s1_valid", 32'(bus.rd_valid), 32'd1);
    cycle(0, 0, 8'h00, 0);
    chk("s1_second", 32'(bus.rd_data), 32'hBB);
    chk("s1_count0", 32'(bus.count), 32'd0);
    cycle(0, 0, 8'h00, 0);

    // fill 64, refuse 65th, drain in order
    for (int i = 0; i < 64; i++) cycle(0, 1, 8'(i), 0);
    chk("s2_full",  32'(bus.full),  32'd1);
    chk("s2_count", 32'(bus.count), 32'd64);
    cycle(0, 1, 8'hFF, 0);
    chk("s2_refused", 32'(bus.count), 32'd64);
`ifdef RAM_FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(bus.overflow), 32'd1);
`endif
    for (int i = 0; i < 64; i++) cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    chk("s2_last", 32'(bus.rd_data), 32'h3F);
    chk("s2_empty", 32'(bus.empty), 32'd1);

    // both asserted at full, then at empty
    for (int i = 0; i < 64; i++) cycle(0, 1, 8'($urandom_range(255)), 0);
    cycle(0, 1, 8'hCC, 1);
    chk("s3_count63", 32'(bus.count), 32'd63);
    for (int i = 0; i < 63; i++) cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(0, 1, 8'hDD, 1);
    chk("s3_count1", 32'(bus.count), 32'd1);
    chk("s3_novalid", 32'(bus.rd_valid), 32'd0);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    chk("s3_dd", 32'(bus.rd_data), 32'hDD);
    cycle(0, 0, 8'h00, 0);

    // interleaved traffic, occupancy 3..10, crosses pointer wrap
    nw = 0;
    nr = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 8'(nw), 0);
      nw++;
    end
    while (nr < 100) begin
      w_s = 1'b0;
      r_s = 1'b0;
      if (nw < 100) begin
        if (q.size() <= 3) w_s = 1'b1;
        else if (q.size() >= 10) r_s = 1'b1;
        else begin
          case ($urandom_range(2))
            0:       w_s = 1'b1;
            1:       r_s = 1'b1;
            default: begin w_s = 1'b1; r_s = 1'b1; end
          endcase
        end
      end else begin
        r_s = 1'b1;
      end
      cycle(0, w_s, 8'(nw), r_s);
      if (w_s) nw++;
      if (r_s) nr++;
    end
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    chk("s4_last", 32'(bus.rd_data), 32'd99);

    // reset mid-operation with a read in flight
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h50 + i), 0);
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    chk("s5_count", 32'(bus.count), 32'd0);
    chk("s5_empty", 32'(bus.empty), 32'd1);
    chk("s5_valid", 32'(bus.rd_valid), 32'd0);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    chk("s5_refused", 32'(bus.rd_valid), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      if (i < 250) cycle(($urandom_range(99) == 0), ($urandom_range(3) != 0), 8'($urandom_range(255)), ($urandom_range(3) == 0));
      else         cycle(($urandom_range(99) == 0), ($urandom_range(3) == 0), 8'($urandom_range(255)), ($urandom_range(3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each stored word.
REQ-002 SHALL have parameter ADDR_W, default 6, giving a depth of 2**ADDR_W = 64 words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1, write request.
REQ-006 SHALL have port wr_data, input, DATA_W, write word.
REQ-007 SHALL have port rd_en, input, 1, read request.
REQ-008 SHALL have port rd_data, output, DATA_W, read word.
REQ-009 SHALL have port rd_valid, output, 1, rd_data holds a newly popped word.
REQ-010 SHALL have port full, output, 1, count == 64.
REQ-011 SHALL have port empty, output, 1, count == 0.
REQ-012 SHALL have port count, output, ADDR_W+1, occupancy 0..64.

Function
REQ-013 SHALL store words in a 64x8 dual-port array: port A is write-only at wr_ptr, and port B is read-only at rd_ptr.
REQ-014 SHALL accept a write only when wr_en=1 and full=0, storing wr_data at wr_ptr and incrementing wr_ptr.
REQ-015 SHALL accept a read only when rd_en=1 and empty=0, incrementing rd_ptr.
REQ-016 SHALL have a read latency of one cycle: an accepted read at edge N gives rd_valid=1 and the word on rd_data after edge N+1.
REQ-017 SHALL hold rd_data at its last value while rd_valid=0.
REQ-018 SHALL, on a write with full=1, ignore the write, leaving the array, pointers and count unchanged.
REQ-019 SHALL, on a read with empty=1, ignore the read and drive rd_valid=0 on the next cycle.
REQ-020 SHALL, on a simultaneous accepted write and read, leave count unchanged and advance both pointers.
REQ-021 SHALL, when full=1 and both wr_en and rd_en are asserted, accept only the read, so count drops to 63.
REQ-022 SHALL, when empty=1 and both wr_en and rd_en are asserted, accept only the write, so count rises to 1.
REQ-023 SHALL wrap wr_ptr and rd_ptr from 63 to 0 modulo 64.
REQ-024 SHALL keep count in ADDR_W+1 bits and never let it exceed 64 or fall below 0.
REQ-025 SHALL derive full and empty from registered count, so the flags change in the cycle after the accepting edge.
REQ-026 SHALL make a word written at edge N readable at the earliest by a read accepted at edge N+1, with no write-through to port B.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, clear wr_ptr, rd_ptr, count, rd_valid and rd_data to 0, and set empty=1 and full=0.
REQ-028 SHALL leave array contents undefined after reset and SHALL NOT clear them.
REQ-029 SHALL give rst priority over wr_en and rd_en in the same cycle, and a mid-operation reset SHALL discard all stored words.
REQ-030 SHALL force rd_valid=0 on the cycle after reset even if a read was accepted on the preceding edge.

Configuration
REQ-031 SHALL, when macro RAM_FIFO_ERR_FLAGS_EN is defined, add outputs overflow (1) and underflow (1).
REQ-032 SHALL set overflow when a write is refused because full=1, and set underflow when a read is refused because empty=1; both SHALL stay set until rst.
REQ-033 SHALL, when RAM_FIFO_ERR_FLAGS_EN is undefined, omit both ports and their logic, with all other behaviour identical.

Structure
REQ-034 SHALL place DATA_W and ADDR_W defaults plus the DEPTH constant (64) in shared package ram_fifo_pkg.
REQ-035 SHALL instantiate the storage array as the existing sub-module dual_port_ram (8-bit data, 6-bit address, registered outputs), with port B's write enable tied to 0.

Verification
REQ-036 SHALL cover this scenario: reset, then write 8'hAA, 8'hBB, then read twice, gives rd_data=AA then BB, each one cycle after its read, and count 0 -> 2 -> 0.
REQ-037 SHALL cover this scenario: 64 writes of 0x00..0x3F give full=1 and count=64; a 65th write of 8'hFF is refused, and 64 reads return 0x00..0x3F in order.
REQ-038 SHALL cover this scenario: at full, wr_en=rd_en=1 with wr_data=8'hCC gives read accepted, write refused and count=63; at empty, both asserted with 8'hDD gives count=1, rd_valid=0, then a read returns DD.
REQ-039 SHALL cover this scenario: 100 writes interleaved with 100 reads, occupancy kept at 3-10, crosses the pointer wrap 63->0 with data in exact order.
REQ-040 SHALL cover this scenario: 5 writes, then rst=1 for one cycle together with rd_en=1, gives count=0, empty=1 and rd_valid=0; a following read is refused.
REQ-041 SHALL cover this scenario: with RAM_FIFO_ERR_FLAGS_EN, a read on empty sets underflow and a write on full sets overflow, both sticky until rst; without the macro, the build has no such ports.
